mem_access_arbiter: RTL and testbench

- Parametrised successor to the processor top-level memory muxing: owns the IRAM/DRAM port and arbitrates between an external host (burst load IRAM, burst load DRAM, burst read-back DRAM) and the processor core.
- Replaces the ad-hoc start/start_2/start_3/start_4 priority chain with one FSM, valid/ready handshakes and auto-incrementing burst addressing.
- Sits between the core, the host interface and both memories.

---
 rtl/mem_access_arbiter_if.sv | 26 ++
 rtl/mem_access_arbiter.sv | 162 ++++++++++++++++
 tb/tb_mem_access_arbiter.sv | 323 ++++++++++++++++++++++++++++++++
 3 files changed

// File: rtl/mem_access_arbiter_if.sv
// rtl/mem_access_arbiter_if.sv - host command/burst bundle between host and arbiter
interface mem_access_arbiter_if #(
  parameter int DATA_W = 16,
  parameter int ADDR_W = 9
);
  logic [1:0]        host_cmd;
  logic              host_cmd_valid;
  logic              host_cmd_ready;
  logic [ADDR_W-1:0] host_addr;
  logic [ADDR_W:0]   host_len;
  logic [DATA_W-1:0] host_wdata;
  logic              host_wvalid;
  logic              host_wready;
  logic [DATA_W-1:0] host_rdata;
  logic              host_rvalid;

  modport master (
    output host_cmd, host_cmd_valid, host_addr, host_len, host_wdata, host_wvalid,
    input  host_cmd_ready, host_wready, host_rdata, host_rvalid
  );

  modport slave (
    input  host_cmd, host_cmd_valid, host_addr, host_len, host_wdata, host_wvalid,
    output host_cmd_ready, host_wready, host_rdata, host_rvalid
  );
endinterface

// File: rtl/mem_access_arbiter.sv
// rtl/mem_access_arbiter.sv - arbitrates IRAM/DRAM between host bursts and the core
module mem_access_arbiter #(
  parameter int DATA_W = 16,
  parameter int ADDR_W = 9,
  parameter int RD_LAT = 1
) (
  input  logic                 clock,
  input  logic                 reset_n,
  mem_access_arbiter_if.slave  host,
  input  logic                 run_req,
  input  logic                 core_halt,
  output logic                 core_en,
  input  logic [ADDR_W-1:0]    core_pc,
  input  logic [ADDR_W-1:0]    core_ar,
  input  logic [DATA_W-1:0]    core_dout,
  input  logic                 core_we,
  input  logic                 core_re_d,
  input  logic                 core_re_i,
  output logic [ADDR_W-1:0]    iram_addr,
  output logic [DATA_W-1:0]    iram_wdata,
  output logic                 iram_we,
  output logic                 iram_re,
  output logic [ADDR_W-1:0]    dram_addr,
  output logic [DATA_W-1:0]    dram_wdata,
  output logic                 dram_we,
  output logic                 dram_re,
  input  logic [DATA_W-1:0]    dram_rdata,
  output logic                 busy,
  output logic                 err
);
  localparam logic [ADDR_W:0]   DEPTH   = {1'b1, {ADDR_W{1'b0}}};
  localparam logic [ADDR_W:0]   CNT_ONE = {{ADDR_W{1'b0}}, 1'b1};
  localparam logic [ADDR_W-1:0] PTR_ONE = {{(ADDR_W-1){1'b0}}, 1'b1};
  localparam logic [1:0] CMD_NONE   = 2'b00;
  localparam logic [1:0] CMD_LOAD_I = 2'b01;
  localparam logic [1:0] CMD_LOAD_D = 2'b10;

  typedef enum logic [2:0] {S_IDLE, S_LOAD_I, S_LOAD_D, S_READ_D, S_DRAIN, S_RUN} state_t;

  state_t            state_q, state_d;
  logic [ADDR_W-1:0] ptr_q, ptr_d;
  logic [ADDR_W:0]   cnt_q, cnt_d;
  logic [RD_LAT-1:0] tag_q, tag_d;
  logic              err_q, err_d;
  logic              rd_issue;
  logic              len_ok;

  assign len_ok = (host.host_len != '0) && (host.host_len <= DEPTH);

  // Each issued read carries a tag that surfaces exactly when its data does.
  if (RD_LAT == 1) begin : g_tag1
    assign tag_d = rd_issue;
  end else begin : g_tagn
    assign tag_d = {tag_q[RD_LAT-2:0], rd_issue};
  end

  assign host.host_rvalid = tag_q[RD_LAT-1];
  assign host.host_rdata  = tag_q[RD_LAT-1] ? dram_rdata : '0;
  assign busy             = (state_q != S_IDLE);
  assign err              = err_q;

  always_comb begin
    state_d             = state_q;
    ptr_d               = ptr_q;
    cnt_d               = cnt_q;
    err_d               = 1'b0;
    rd_issue            = 1'b0;
    host.host_cmd_ready = 1'b0;
    host.host_wready    = 1'b0;
    core_en             = 1'b0;
    iram_addr           = '0;
    iram_wdata          = '0;
    iram_we             = 1'b0;
    iram_re             = 1'b0;
    dram_addr           = '0;
    dram_wdata          = '0;
    dram_we             = 1'b0;
    dram_re             = 1'b0;

    case (state_q)
      S_IDLE: begin
        host.host_cmd_ready = 1'b1;
        if (host.host_cmd_valid && host.host_cmd != CMD_NONE) begin
          if (len_ok) begin
            ptr_d = host.host_addr;
            cnt_d = host.host_len;
            case (host.host_cmd)
              CMD_LOAD_I: state_d = S_LOAD_I;
              CMD_LOAD_D: state_d = S_LOAD_D;
              default:    state_d = S_READ_D;
            endcase
          end else begin
            err_d = 1'b1;
          end
        end else if (run_req) begin
          state_d = S_RUN;
        end
      end

      S_LOAD_I, S_LOAD_D: begin
        host.host_wready = 1'b1;
        if (host.host_wvalid) begin
          if (state_q == S_LOAD_I) begin
            iram_we    = 1'b1;
            iram_addr  = ptr_q;
            iram_wdata = host.host_wdata;
          end else begin
            dram_we    = 1'b1;
            dram_addr  = ptr_q;
            dram_wdata = host.host_wdata;
          end
          ptr_d = ptr_q + PTR_ONE;
          cnt_d = cnt_q - CNT_ONE;
          if (cnt_q == CNT_ONE) state_d = S_IDLE;
        end
      end

      S_READ_D: begin
        dram_re   = 1'b1;
        dram_addr = ptr_q;
        rd_issue  = 1'b1;
        ptr_d     = ptr_q + PTR_ONE;
        cnt_d     = cnt_q - CNT_ONE;
        if (cnt_q == CNT_ONE) state_d = S_DRAIN;
      end

      S_DRAIN: begin
        if (tag_q == '0) state_d = S_IDLE;
      end

      S_RUN: begin
        core_en    = 1'b1;
        iram_addr  = core_pc;
        iram_re    = core_re_i;
        dram_addr  = core_ar;
        dram_wdata = core_dout;
        dram_we    = core_we;
        dram_re    = core_re_d;
        if (host.host_cmd_valid) err_d = 1'b1;
        if (core_halt) state_d = S_IDLE;
      end

      default: state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      state_q <= S_IDLE;
      ptr_q   <= '0;
      cnt_q   <= '0;
      tag_q   <= '0;
      err_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      ptr_q   <= ptr_d;
      cnt_q   <= cnt_d;
      tag_q   <= tag_d;
      err_q   <= err_d;
    end
  end
endmodule

// File: tb/tb_mem_access_arbiter.sv
// tb/tb_mem_access_arbiter.sv - directed bench, twin DUTs with RD_LAT 1 and 3
module tb_mem_access_arbiter;
  logic clock = 1'b0;
  always #5 clock = ~clock;

  logic        reset_n;
  logic [1:0]  h_cmd;
  logic        h_cmd_valid;
  logic [8:0]  h_addr;
  logic [9:0]  h_len;
  logic [15:0] h_wdata;
  logic        h_wvalid;
  logic        run_req, core_halt, core_we, core_re_d, core_re_i;
  logic [8:0]  core_pc, core_ar;
  logic [15:0] core_dout;

  logic        a_core_en, a_iram_we, a_iram_re, a_dram_we, a_dram_re, a_busy, a_err;
  logic [8:0]  a_iram_addr, a_dram_addr;
  logic [15:0] a_iram_wdata, a_dram_wdata, a_dram_rdata;
  logic        b_core_en, b_iram_we, b_iram_re, b_dram_we, b_dram_re, b_busy, b_err;
  logic [8:0]  b_iram_addr, b_dram_addr;
  logic [15:0] b_iram_wdata, b_dram_wdata, b_dram_rdata;

  int errors = 0;
  int checks = 0;
  int cyc = 0;
  int a_iwe_cnt = 0;

  mem_access_arbiter_if #(.DATA_W(16), .ADDR_W(9)) ha ();
  mem_access_arbiter_if #(.DATA_W(16), .ADDR_W(9)) hb ();

  assign ha.host_cmd = h_cmd;        assign hb.host_cmd = h_cmd;
  assign ha.host_cmd_valid = h_cmd_valid; assign hb.host_cmd_valid = h_cmd_valid;
  assign ha.host_addr = h_addr;      assign hb.host_addr = h_addr;
  assign ha.host_len = h_len;        assign hb.host_len = h_len;
  assign ha.host_wdata = h_wdata;    assign hb.host_wdata = h_wdata;
  assign ha.host_wvalid = h_wvalid;  assign hb.host_wvalid = h_wvalid;

  mem_access_arbiter #(.DATA_W(16), .ADDR_W(9), .RD_LAT(1)) dut_a (
    .clock(clock), .reset_n(reset_n), .host(ha), .run_req(run_req), .core_halt(core_halt),
    .core_en(a_core_en), .core_pc(core_pc), .core_ar(core_ar), .core_dout(core_dout),
    .core_we(core_we), .core_re_d(core_re_d), .core_re_i(core_re_i),
    .iram_addr(a_iram_addr), .iram_wdata(a_iram_wdata), .iram_we(a_iram_we), .iram_re(a_iram_re),
    .dram_addr(a_dram_addr), .dram_wdata(a_dram_wdata), .dram_we(a_dram_we), .dram_re(a_dram_re),
    .dram_rdata(a_dram_rdata), .busy(a_busy), .err(a_err)
  );

  mem_access_arbiter #(.DATA_W(16), .ADDR_W(9), .RD_LAT(3)) dut_b (
    .clock(clock), .reset_n(reset_n), .host(hb), .run_req(run_req), .core_halt(core_halt),
    .core_en(b_core_en), .core_pc(core_pc), .core_ar(core_ar), .core_dout(core_dout),
    .core_we(core_we), .core_re_d(core_re_d), .core_re_i(core_re_i),
    .iram_addr(b_iram_addr), .iram_wdata(b_iram_wdata), .iram_we(b_iram_we), .iram_re(b_iram_re),
    .dram_addr(b_dram_addr), .dram_wdata(b_dram_wdata), .dram_we(b_dram_we), .dram_re(b_dram_re),
    .dram_rdata(b_dram_rdata), .busy(b_busy), .err(b_err)
  );

  logic [15:0] a_iram [512];
  logic [15:0] a_dram [512];
  logic [15:0] b_dram [512];
  logic [15:0] a_rd, b_p0, b_p1, b_p2;

  always @(posedge clock) begin
    if (a_iram_we) a_iram[a_iram_addr] <= a_iram_wdata;
    if (a_dram_we) a_dram[a_dram_addr] <= a_dram_wdata;
    if (b_dram_we) b_dram[b_dram_addr] <= b_dram_wdata;
    a_rd <= a_dram_re ? a_dram[a_dram_addr] : 16'hDEAD;
    b_p0 <= b_dram_re ? b_dram[b_dram_addr] : 16'hDEAD;
    b_p1 <= b_p0;
    b_p2 <= b_p1;
    if (a_iram_we) a_iwe_cnt <= a_iwe_cnt + 1;
    cyc <= cyc + 1;
  end
  assign a_dram_rdata = a_rd;
  assign b_dram_rdata = b_p2;

  task automatic tick();
    @(posedge clock);
    #1;
  endtask

  task automatic issue_cmd(input logic [1:0] cmd, input logic [8:0] addr, input logic [9:0] len);
    h_cmd = cmd; h_addr = addr; h_len = len; h_cmd_valid = 1'b1;
    #1;
    checks++;
    if (ha.host_cmd_ready !== 1'b1) begin
      errors++; $display("FAIL cmd_ready: got %b want 1", ha.host_cmd_ready);
    end
    tick();
    h_cmd_valid = 1'b0; h_cmd = 2'b00;
    #1;
  endtask

  task automatic load_burst(input logic [1:0] cmd, input logic [8:0] addr, input int len,
                            input logic [15:0] base, input bit gaps);
    logic [8:0]  a, ad;
    logic        we;
    logic [15:0] wd;
    int sent, n;
    issue_cmd(cmd, addr, 10'(len));
    a = addr; sent = 0; n = 0;
    while (sent < len && n < 4 * len + 20) begin
      h_wvalid = gaps ? ($urandom_range(0, 3) != 0) : 1'b1;
      h_wdata  = base + 16'(sent);
      #1;
      if (cmd == 2'b01) begin we = a_iram_we; ad = a_iram_addr; wd = a_iram_wdata; end
      else              begin we = a_dram_we; ad = a_dram_addr; wd = a_dram_wdata; end
      checks++;
      if (we !== h_wvalid || ha.host_wready !== 1'b1 || a_core_en !== 1'b0 ||
          (h_wvalid && (ad !== a || wd !== h_wdata))) begin
        errors++;
        $display("FAIL load word %0d: we=%b addr=%h data=%h en=%b want we=%b addr=%h data=%h en=0",
                 sent, we, ad, wd, a_core_en, h_wvalid, a, h_wdata);
      end
      if (h_wvalid) begin a = a + 9'd1; sent++; end
      tick();
      n++;
    end
    h_wvalid = 1'b0;
    #1;
    checks++;
    if (sent != len || a_busy !== 1'b0) begin
      errors++; $display("FAIL load end: sent=%0d busy=%b want %0d busy=0", sent, a_busy, len);
    end
  endtask

  task automatic read_burst(input logic [8:0] addr, input int len, input logic [15:0] exp [4]);
    int ka, kb, t0;
    issue_cmd(2'b11, addr, 10'(len));
    checks++;
    if (a_dram_re !== 1'b1 || a_dram_addr !== addr || b_dram_re !== 1'b1) begin
      errors++; $display("FAIL read issue: re=%b addr=%h want re=1 addr=%h", a_dram_re, a_dram_addr, addr);
    end
    t0 = cyc; ka = 0; kb = 0;
    for (int i = 0; i < 12; i++) begin
      tick();
      if (ha.host_rvalid === 1'b1) begin
        checks++;
        if (ka >= len || ha.host_rdata !== exp[ka & 3] || (ka == 0 && cyc - t0 != 1)) begin
          errors++; $display("FAIL rd_lat1 word %0d: data=%h lat=%0d want %h lat=1",
                             ka, ha.host_rdata, cyc - t0, exp[ka & 3]);
        end
        ka++;
      end
      if (hb.host_rvalid === 1'b1) begin
        checks++;
        if (kb >= len || hb.host_rdata !== exp[kb & 3] || (kb == 0 && cyc - t0 != 3)) begin
          errors++; $display("FAIL rd_lat3 word %0d: data=%h lat=%0d want %h lat=3",
                             kb, hb.host_rdata, cyc - t0, exp[kb & 3]);
        end
        kb++;
      end
    end
    checks++;
    if (ka != len || kb != len || a_busy !== 1'b0 || b_busy !== 1'b0) begin
      errors++; $display("FAIL read count: lat1=%0d lat3=%0d busy=%b%b want %0d idle", ka, kb, a_busy, b_busy, len);
    end
  endtask

  task automatic test_reset();
    reset_n = 1'b0; h_cmd = 2'b00; h_cmd_valid = 1'b0; h_addr = '0; h_len = '0;
    h_wdata = '0; h_wvalid = 1'b0; run_req = 1'b0; core_halt = 1'b0; core_we = 1'b0;
    core_re_d = 1'b0; core_re_i = 1'b0; core_pc = '0; core_ar = '0; core_dout = '0;
    #3;
    checks++;
    if ({ha.host_cmd_ready, a_busy, a_err, a_core_en, a_iram_we, a_dram_we, a_dram_re,
         ha.host_wready, ha.host_rvalid} !== 9'b100000000) begin
      errors++; $display("FAIL reset outputs: got %b want 100000000",
        {ha.host_cmd_ready, a_busy, a_err, a_core_en, a_iram_we, a_dram_we, a_dram_re,
         ha.host_wready, ha.host_rvalid});
    end
    @(negedge clock); reset_n = 1'b1;
    tick();
  endtask

  task automatic test_load_iram_wrap();
    int n0;
    n0 = a_iwe_cnt;
    load_burst(2'b01, 9'h1F0, 32, 16'h1000, 1'b1);
    checks++;
    if (a_iwe_cnt - n0 != 32 || a_iram[9'h1F0] !== 16'h1000 || a_iram[9'h1FF] !== 16'h100F ||
        a_iram[9'h000] !== 16'h1010 || a_iram[9'h00F] !== 16'h101F) begin
      errors++; $display("FAIL iram wrap: pulses=%0d [1F0]=%h [1FF]=%h [000]=%h [00F]=%h want 32 1000 100F 1010 101F",
        a_iwe_cnt - n0, a_iram[9'h1F0], a_iram[9'h1FF], a_iram[9'h000], a_iram[9'h00F]);
    end
  endtask

  task automatic test_readback();
    logic [15:0] exp [4];
    exp = '{16'hA5A0, 16'hA5A1, 16'hA5A2, 16'hA5A3};
    load_burst(2'b10, 9'h010, 4, 16'hA5A0, 1'b0);
    read_burst(9'h010, 4, exp);
  endtask

  task automatic test_errors();
    logic [9:0] bad [2];
    bad = '{10'd0, 10'd513};
    for (int i = 0; i < 2; i++) begin
      h_cmd = 2'b01; h_addr = 9'h000; h_len = bad[i]; h_cmd_valid = 1'b1;
      tick();
      h_cmd_valid = 1'b0;
      #1;
      checks++;
      if (a_err !== 1'b1 || a_busy !== 1'b0 || b_err !== 1'b1) begin
        errors++; $display("FAIL bad len %0d: err=%b busy=%b want err=1 busy=0", bad[i], a_err, a_busy);
      end
      tick();
      checks++;
      if (a_err !== 1'b0 || a_busy !== 1'b0) begin
        errors++; $display("FAIL err pulse width len %0d: err=%b busy=%b want 0 0", bad[i], a_err, a_busy);
      end
    end
  endtask

  task automatic test_run();
    logic [15:0] exp [4];
    exp = '{16'hBEEF, 16'h0000, 16'h0000, 16'h0000};
    run_req = 1'b1;
    tick();
    run_req = 1'b0; core_we = 1'b1; core_ar = 9'd5; core_dout = 16'hBEEF;
    core_re_i = 1'b1; core_pc = 9'h033;
    #1;
    checks++;
    if ({a_core_en, a_busy, a_dram_we, a_iram_re, a_iram_we} !== 5'b11110 ||
        a_dram_addr !== 9'd5 || a_dram_wdata !== 16'hBEEF || a_iram_addr !== 9'h033) begin
      errors++; $display("FAIL run passthrough: en/busy/we/re_i/iwe=%b ar=%h dout=%h pc=%h want 11110 005 BEEF 033",
        {a_core_en, a_busy, a_dram_we, a_iram_re, a_iram_we}, a_dram_addr, a_dram_wdata, a_iram_addr);
    end
    tick();
    core_we = 1'b0; core_re_i = 1'b0;
    h_cmd = 2'b10; h_addr = 9'h000; h_len = 10'd1; h_cmd_valid = 1'b1; h_wvalid = 1'b1;
    #1;
    checks++;
    if ({ha.host_cmd_ready, ha.host_wready, a_iram_we, a_dram_we, a_dram_re} !== 5'b00000) begin
      errors++; $display("FAIL run host blocked: rdy/wrdy/iwe/dwe/dre=%b want 00000",
        {ha.host_cmd_ready, ha.host_wready, a_iram_we, a_dram_we, a_dram_re});
    end
    tick();
    h_cmd_valid = 1'b0; h_wvalid = 1'b0; h_cmd = 2'b00;
    #1;
    checks++;
    if (a_err !== 1'b1 || a_core_en !== 1'b1) begin
      errors++; $display("FAIL run cmd err: err=%b en=%b want 1 1", a_err, a_core_en);
    end
    core_halt = 1'b1;
    #1;
    checks++;
    if (a_core_en !== 1'b1) begin
      errors++; $display("FAIL halt same cycle: en=%b want 1", a_core_en);
    end
    tick();
    core_halt = 1'b0;
    #1;
    checks++;
    if (a_core_en !== 1'b0 || a_busy !== 1'b0) begin
      errors++; $display("FAIL halt next cycle: en=%b busy=%b want 0 0", a_core_en, a_busy);
    end
    read_burst(9'd5, 1, exp);
  endtask

  task automatic test_priority();
    run_req = 1'b1;
    load_burst(2'b10, 9'h100, 2, 16'h5500, 1'b0);
    tick();
    checks++;
    if (a_core_en !== 1'b1 || a_dram[9'h100] !== 16'h5500 || a_dram[9'h101] !== 16'h5501) begin
      errors++; $display("FAIL priority: en=%b [100]=%h [101]=%h want 1 5500 5501",
        a_core_en, a_dram[9'h100], a_dram[9'h101]);
    end
    run_req = 1'b0; core_halt = 1'b1;
    tick();
    core_halt = 1'b0;
    #1;
  endtask

  task automatic test_reset_mid_burst();
    issue_cmd(2'b01, 9'h040, 10'd8);
    for (int i = 0; i < 3; i++) begin
      h_wvalid = 1'b1; h_wdata = 16'h7700 + 16'(i);
      tick();
    end
    h_wdata = 16'h7703;
    reset_n = 1'b0;
    #1;
    checks++;
    if ({a_iram_we, ha.host_wready, a_busy, ha.host_cmd_ready, a_core_en} !== 5'b00010) begin
      errors++; $display("FAIL async reset: iwe/wrdy/busy/rdy/en=%b want 00010",
        {a_iram_we, ha.host_wready, a_busy, ha.host_cmd_ready, a_core_en});
    end
    tick();
    checks++;
    if (a_iram[9'h042] !== 16'h7702 || a_iram[9'h043] === 16'h7703) begin
      errors++; $display("FAIL reset abort: [042]=%h [043]=%h want 7702 and 043 unwritten",
        a_iram[9'h042], a_iram[9'h043]);
    end
    h_wvalid = 1'b0;
    reset_n = 1'b1;
    tick();
    load_burst(2'b01, 9'h080, 8, 16'h7800, 1'b0);
    checks++;
    if (a_iram[9'h080] !== 16'h7800 || a_iram[9'h087] !== 16'h7807) begin
      errors++; $display("FAIL burst after reset: [080]=%h [087]=%h want 7800 7807",
        a_iram[9'h080], a_iram[9'h087]);
    end
  endtask

  initial begin
    #200000;
    $display("FAIL timeout: bench did not finish");
    $fatal(1, "timeout");
  end

  initial begin
    test_reset();
    test_load_iram_wrap();
    test_readback();
    test_errors();
    test_run();
    test_priority();
    test_reset_mid_burst();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
